inta_seq: RTL and testbench
===========================

# inta_seq

Interrupt-acknowledge and EOI sequencer for the 8259 block, 8086 mode, fully nested fixed priority (IR0 highest). Sits between the CPU bus and the in-service register. Raises INT to the CPU, runs the two-pulse INTA cycle, and drives the vector onto the data bus. Generates the one-cycle `set`/`clr` pulses that the in-service register consumes and decodes OCW2 EOI commands into `clr`.

## Interface
- No parameters; the width is fixed at 8 IR lines.
- `clk` in 1: system clock; all inputs are synchronous to it.
- `rst_n` in 1: asynchronous active-low reset.
- `irr` in 8: pending requests from the request register.
- `imr` in 8: mask; 1 = masked.
- `isr` in 8: current in-service contents, fed back from the in-service register.
- `inta_n` in 1: CPU acknowledge strobe, active low.
- `vec_base` in 5: ICW2 T7..T3.
- `eoi_wr` in 1: one-cycle OCW2 write strobe.
- `eoi_cmd` in 3: OCW2 bits 7:5 (R, SL, EOI).
- `eoi_lvl` in 3: OCW2 bits 2:0.
- `int_o` out 1: interrupt request to the CPU.
- `set` out 8: one-hot one-cycle pulse that sets an in-service bit.
- `clr` out 8: one-hot one-cycle pulse that clears an in-service bit.
- `dout` out 8: vector byte.
- `dout_en` out 1: bus drive enable for `dout`.

## Operation
- **Candidate:** the highest-priority bit of `irr & ~imr` whose index is strictly below the highest-priority set bit of `isr` (any index if `isr` == 0).
- **`int_o`:** registered. It is 1 in IDLE when a candidate exists. It is forced to 0 in ACK1, GAP and ACK2.
- **Edge detect:** `inta_q` registers `inta_n`.
  - Falling edge: `inta_n`=0 and `inta_q`=1.
  - Rising edge: `inta_n`=1 and `inta_q`=0.
- **States:** IDLE, ACK1, GAP, ACK2.
  - IDLE → ACK1 on a falling edge. In that cycle, latch `win` = candidate index.
    - If there is no candidate: `win` = 7 and `spur` = 1.
    - Otherwise `spur` = 0.
  - ACK1 → GAP on a rising edge.
  - GAP → ACK2 on a falling edge.
  - ACK2 → IDLE on a rising edge.
  - A falling edge in ACK1 or ACK2 cannot occur and is ignored.
- **`set`:** on entry to ACK1, `set[win]` pulses for exactly one cycle. No pulse if `spur` = 1.
- **`dout`:** in ACK2, `dout` = {`vec_base`, `win`} and `dout_en` = 1. Outside ACK2, `dout` = 0 and `dout_en` = 0.
- **EOI decode** (on `eoi_wr`):
  - `eoi_cmd` 3'b001, non-specific: clear the highest-priority set bit of `isr`. No pulse if `isr` == 0.
  - `eoi_cmd` 3'b011, specific: clear bit `eoi_lvl`.
  - All other codes are ignored; no `clr` pulse.
  - EOI decode is accepted in every state.
- **Collision rule:** if `eoi_wr` arrives in the same cycle that the `set` pulse is being registered, it is held in a one-entry pending register.
  - It is issued one cycle later, computed from `isr` at issue time.
  - `set` and `clr` are never nonzero in the same cycle.
  - A second `eoi_wr` while one is pending overwrites the pending command.

## Timing
- Reset values:
  - state = IDLE
  - `int_o`, `set`, `clr`, `dout`, `dout_en` = 0
  - `inta_q` = 1
  - `win` = 0, `spur` = 0, pending EOI cleared
- `int_o` latency: a candidate appearing in cycle N gives `int_o`=1 in cycle N+1.
- `set` latency: falling edge detected at edge N → `set` high during cycle N+1 only.
- `dout_en` latency:
  - Asserts the cycle after the second falling edge is detected.
  - Deasserts the cycle after the rising edge is detected.
- `clr` latency: `eoi_wr` in cycle N → `clr` high in cycle N+1, or N+2 when deferred by the collision rule.
- Changes to `irr` or `imr` after the ACK1 latch do not alter `win`.
- A request that drops between INT and the first INTA gives a spurious IR7 vector and no `set`.
- `rst_n` low mid-cycle: all outputs drop immediately (asynchronous). The sequencer restarts in IDLE and waits for a fresh falling edge.

## Structure
- Package `i8259_pkg`:
  - state enum (IDLE, ACK1, GAP, ACK2)
  - OCW2 code constants `OCW2_NSEOI` = 3'b001 and `OCW2_SEOI` = 3'b011
  - `SPUR_LVL` = 3'd7
- One sub-module, `prio_enc8`:
  - 8-bit request in; 3-bit index and valid out.
  - Lowest index wins.
  - Instantiated twice: once on `irr & ~imr`, once on `isr`.

## Test plan
- **Normal acknowledge:** `irr`=8'h08, `imr`=0, `isr`=0, `vec_base`=5'h11.
  - `int_o`=1.
  - On the first INTA, `set`=8'h08 for one cycle.
  - In the second INTA, `dout`=8'h8B with `dout_en`=1.
- **Nesting:** `isr`=8'h04, `irr`=8'h30 → `int_o` stays 0. `irr`=8'h02 → `int_o`=1, and on INTA `set`=8'h02.
- **Spurious:** `int_o`=1 from `irr`=8'h01, then `irr` drops to 0 before INTA.
  - No `set` pulse.
  - `dout` = {`vec_base`, 3'd7}.
- **EOI decode:**
  - `isr`=8'h0A, non-specific EOI → `clr`=8'h02.
  - Specific EOI with `eoi_lvl`=3 → `clr`=8'h08.
  - `eoi_cmd`=3'b101 → `clr` stays 0.
- **Collision:** `eoi_wr` in the same cycle as the `set` pulse.
  - `clr` appears one cycle after `set`.
  - Never in the same cycle as `set`.
- **Reset mid-operation:** `rst_n` pulsed low during ACK2.
  - `dout_en` drops at once and state = IDLE.
  - The next INTA is treated as a first pulse.

Source files
------------

// File: rtl/i8259_pkg.sv
// i8259_pkg: shared types and constants for the 8259 interrupt-acknowledge
// sequencer.
//   state_e     : acknowledge sequencer states
//   OCW2_*      : OCW2 bits 7:5 command codes that produce an EOI
//   SPUR_LVL    : level reported for a spurious acknowledge
//   onehot8()   : 3-bit index to one-hot byte
package i8259_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } state_e;

  localparam logic [2:0] OCW2_NSEOI = 3'b001;
  localparam logic [2:0] OCW2_SEOI  = 3'b011;
  localparam logic [2:0] SPUR_LVL   = 3'd7;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: 8-input fixed-priority encoder, lowest index wins.
//   req_i   : request vector
//   idx_o   : index of the lowest set bit (0 when nothing is set)
//   valid_o : at least one request bit is set
module prio_enc8 (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       valid_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o   = 3'd0;
    valid_o = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 3'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inta_seq.sv
// inta_seq: interrupt-acknowledge and EOI sequencer, 8086 mode, fully nested
// fixed priority (IR0 highest).
//   clk, rst_n   : clock, asynchronous active-low reset
//   irr, imr     : pending requests and mask (1 = masked)
//   isr          : in-service register contents (feedback)
//   inta_n       : CPU acknowledge strobe, active low
//   vec_base     : ICW2 T7..T3
//   eoi_wr       : one-cycle OCW2 write strobe, with eoi_cmd (R,SL,EOI), eoi_lvl
//   int_o        : interrupt request to the CPU
//   set, clr     : one-hot one-cycle pulses to the in-service register
//   dout, dout_en: vector byte and its bus drive enable
//   dbg_state_o, dbg_spur_o : sequencer state and latched spurious flag
//
// Strobe semantics: eoi_wr is a single-cycle command qualifier with no
// back-pressure; every strobe is consumed in the cycle it is high (or parked
// for exactly one cycle when it collides with a set pulse). set/clr are
// single-cycle pulses the in-service register must accept unconditionally.
module inta_seq
  import i8259_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [7:0] isr,
  input  logic       inta_n,
  input  logic [4:0] vec_base,
  input  logic       eoi_wr,
  input  logic [2:0] eoi_cmd,
  input  logic [2:0] eoi_lvl,
  output logic       int_o,
  output logic [7:0] set,
  output logic [7:0] clr,
  output logic [7:0] dout,
  output logic       dout_en,
  output state_e     dbg_state_o,
  output logic       dbg_spur_o
);

  state_e     state_q, state_d;
  logic       inta_q;
  logic [2:0] win_q, win_d;
  logic       spur_q, spur_d;
  logic       int_q, int_d;
  logic [7:0] set_q, set_d;
  logic [7:0] clr_q, clr_d;
  logic       pend_v_q, pend_v_d;
  logic [2:0] pend_cmd_q, pend_cmd_d;
  logic [2:0] pend_lvl_q, pend_lvl_d;

  logic [2:0] req_idx, isr_idx;
  logic       req_v, isr_v, cand_v;
  logic       fall, rise;
  logic       issue_v;
  logic [2:0] issue_cmd, issue_lvl;

  prio_enc8 u_req_enc (.req_i(irr & ~imr), .idx_o(req_idx), .valid_o(req_v));
  prio_enc8 u_isr_enc (.req_i(isr),        .idx_o(isr_idx), .valid_o(isr_v));

  // Fully nested: only a request strictly above the current in-service
  // level may interrupt.
  assign cand_v = req_v && (!isr_v || (req_idx < isr_idx));

  assign fall = ~inta_n & inta_q;
  assign rise = inta_n & ~inta_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    spur_d  = spur_q;
    set_d   = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = ACK1;
          if (cand_v) begin
            win_d  = req_idx;
            spur_d = 1'b0;
            set_d  = onehot8(req_idx);
          end else begin
            win_d  = SPUR_LVL;
            spur_d = 1'b1;
          end
        end
      end
      ACK1:    if (rise) state_d = GAP;
      GAP:     if (fall) state_d = ACK2;
      ACK2:    if (rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    int_d = (state_d == IDLE) && cand_v;
  end

  // EOI issue path. A strobe that lands while a set pulse is being
  // registered is parked so the clear is computed against the in-service
  // contents that already include that set.
  always_comb begin
    pend_v_d   = 1'b0;
    pend_cmd_d = pend_cmd_q;
    pend_lvl_d = pend_lvl_q;
    issue_v    = 1'b0;
    issue_cmd  = pend_cmd_q;
    issue_lvl  = pend_lvl_q;
    clr_d      = 8'h00;
    if (eoi_wr && (set_d != 8'h00)) begin
      pend_v_d   = 1'b1;
      pend_cmd_d = eoi_cmd;
      pend_lvl_d = eoi_lvl;
    end else begin
      issue_v = eoi_wr | pend_v_q;
      if (eoi_wr) begin
        issue_cmd = eoi_cmd;
        issue_lvl = eoi_lvl;
      end
      if (issue_v) begin
        if (issue_cmd == OCW2_NSEOI) begin
          if (isr_v) clr_d = onehot8(isr_idx);
        end else if (issue_cmd == OCW2_SEOI) begin
          clr_d = onehot8(issue_lvl);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inta_q     <= 1'b1;
      win_q      <= 3'd0;
      spur_q     <= 1'b0;
      int_q      <= 1'b0;
      set_q      <= 8'h00;
      clr_q      <= 8'h00;
      pend_v_q   <= 1'b0;
      pend_cmd_q <= 3'd0;
      pend_lvl_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      inta_q     <= inta_n;
      win_q      <= win_d;
      spur_q     <= spur_d;
      int_q      <= int_d;
      set_q      <= set_d;
      clr_q      <= clr_d;
      pend_v_q   <= pend_v_d;
      pend_cmd_q <= pend_cmd_d;
      pend_lvl_q <= pend_lvl_d;
    end
  end

  assign int_o       = int_q;
  assign set         = set_q;
  assign clr         = clr_q;
  assign dout_en     = (state_q == ACK2);
  assign dout        = dout_en ? {vec_base, win_q} : 8'h00;
  assign dbg_state_o = state_q;
  assign dbg_spur_o  = spur_q;

endmodule

// File: tb/tb_inta_seq.sv
module tb_inta_seq;
  import i8259_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] irr, imr, isr;
  logic       inta_n;
  logic [4:0] vec_base;
  logic       eoi_wr;
  logic [2:0] eoi_cmd, eoi_lvl;
  logic       int_o;
  logic [7:0] set, clr, dout;
  logic       dout_en;
  state_e     dbg_state;
  logic       dbg_spur;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  inta_seq dut (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .isr(isr),
    .inta_n(inta_n), .vec_base(vec_base), .eoi_wr(eoi_wr),
    .eoi_cmd(eoi_cmd), .eoi_lvl(eoi_lvl), .int_o(int_o), .set(set),
    .clr(clr), .dout(dout), .dout_en(dout_en),
    .dbg_state_o(dbg_state), .dbg_spur_o(dbg_spur)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Lowest set index, 8 when empty.
  function automatic int low_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  // Candidate level under full nesting, -1 when none.
  function automatic int cand(input logic [7:0] r, input logic [7:0] m, input logic [7:0] s);
    int a, b;
    a = low_idx(r & ~m);
    b = low_idx(s);
    return (a < 8 && a < b) ? a : -1;
  endfunction

  function automatic logic [7:0] eoi_exp(input logic [2:0] cmd, input logic [2:0] lvl,
                                         input logic [7:0] s);
    logic [7:0] one;
    one = 8'd1;
    if (cmd == 3'b001) return s & (~s + 8'd1);   // lowest set bit
    if (cmd == 3'b011) return one << lvl;
    return 8'h00;
  endfunction

  // set and clr must never overlap; each is one-hot or zero.
  always @(negedge clk) begin
    if (rst_n) begin
      check("set_clr_excl", {31'd0, (set != 8'h00) && (clr != 8'h00)}, 32'd0);
      check("set_onehot0", {31'd0, $onehot0(set)}, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end on a negedge, after sampling and before driving.
  task automatic do_eoi(input logic [2:0] cmd, input logic [2:0] lvl);
    exp_q.push_back(eoi_exp(cmd, lvl, isr));
    eoi_wr = 1'b1; eoi_cmd = cmd; eoi_lvl = lvl;
    @(negedge clk);
    eoi_wr = 1'b0;
    check("eoi_clr", {24'd0, clr}, {24'd0, exp_q.pop_front()});
    @(negedge clk);
    check("eoi_clr_gone", {24'd0, clr}, 32'd0);
  endtask

  task automatic do_ack(input bit collide, input logic [2:0] ecmd, input logic [2:0] elvl,
                        input bit change_irr);
    int         c;
    logic [2:0] w;
    logic [7:0] es;
    logic [7:0] one;
    logic [7:0] exp_vec;
    one = 8'd1;
    c  = cand(irr, imr, isr);
    w  = (c >= 0) ? 3'(c) : 3'd7;
    es = (c >= 0) ? (one << c) : 8'h00;
    inta_n = 1'b0;
    if (collide) begin
      exp_q.push_back(eoi_exp(ecmd, elvl, isr));
      eoi_wr = 1'b1; eoi_cmd = ecmd; eoi_lvl = elvl;
    end
    @(negedge clk);
    eoi_wr = 1'b0;
    check("set_pulse", {24'd0, set}, {24'd0, es});
    check("int_in_ack1", {31'd0, int_o}, 32'd0);
    check("spur_flag", {31'd0, dbg_spur}, {31'd0, c < 0});
    if (collide && c < 0) check("clr_spur_nodefer", {24'd0, clr}, {24'd0, exp_q.pop_front()});
    if (collide && c >= 0) check("clr_deferred_0", {24'd0, clr}, 32'd0);
    if (change_irr) begin
      irr = 8'($urandom);
      imr = 8'($urandom) & 8'($urandom);
    end
    @(negedge clk);
    check("set_one_cycle", {24'd0, set}, 32'd0);
    if (collide && c >= 0) check("clr_deferred", {24'd0, clr}, {24'd0, exp_q.pop_front()});
    repeat ($urandom_range(0, 2)) @(negedge clk);
    inta_n = 1'b1;
    @(negedge clk);
    check("gap_no_drive", {31'd0, dout_en}, 32'd0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    inta_n = 1'b0;
    @(negedge clk);
    exp_vec = {vec_base, w};
    check("ack2_dout_en", {31'd0, dout_en}, 32'd1);
    check("ack2_dout", {24'd0, dout}, {24'd0, exp_vec});
    check("ack2_int", {31'd0, int_o}, 32'd0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    inta_n = 1'b1;
    @(negedge clk);
    check("end_dout_en", {31'd0, dout_en}, 32'd0);
    check("end_dout", {24'd0, dout}, 32'd0);
    check("end_int", {31'd0, int_o}, {31'd0, cand(irr, imr, isr) >= 0});
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] cmd_tab [5];

  initial begin
    cmd_tab[0] = 3'b001; cmd_tab[1] = 3'b011; cmd_tab[2] = 3'b101;
    cmd_tab[3] = 3'b000; cmd_tab[4] = 3'b111;
    rst_n = 1'b0; irr = 8'h00; imr = 8'h00; isr = 8'h00; inta_n = 1'b1;
    vec_base = 5'h00; eoi_wr = 1'b0; eoi_cmd = 3'd0; eoi_lvl = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_int", {31'd0, int_o}, 32'd0);
    check("rst_set", {24'd0, set}, 32'd0);
    check("rst_clr", {24'd0, clr}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_dout_en", {31'd0, dout_en}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst_n = 1'b1;
    @(negedge clk);

    // Normal acknowledge
    irr = 8'h08; vec_base = 5'h11;
    @(negedge clk);
    check("norm_int", {31'd0, int_o}, 32'd1);
    do_ack(1'b0, 3'd0, 3'd0, 1'b0);
    check("norm_vec_literal", {24'd0, 8'h8B}, {24'd0, vec_base, 3'd3});

    // Nesting
    isr = 8'h04; irr = 8'h30;
    @(negedge clk);
    check("nest_blocked", {31'd0, int_o}, 32'd0);
    irr = 8'h02;
    @(negedge clk);
    check("nest_int", {31'd0, int_o}, 32'd1);
    do_ack(1'b0, 3'd0, 3'd0, 1'b0);

    // Spurious: request drops on the way into the acknowledge
    isr = 8'h00; irr = 8'h01;
    @(negedge clk);
    check("spur_int", {31'd0, int_o}, 32'd1);
    irr = 8'h00;
    do_ack(1'b0, 3'd0, 3'd0, 1'b0);

    // EOI decode
    isr = 8'h0A;
    do_eoi(3'b001, 3'd0);
    do_eoi(3'b011, 3'd3);
    do_eoi(3'b101, 3'd3);
    isr = 8'h00;
    do_eoi(3'b001, 3'd5);

    // Collision with the set pulse
    irr = 8'h08; isr = 8'h00;
    @(negedge clk);
    do_ack(1'b1, 3'b011, 3'd3, 1'b0);
    isr = 8'h40;
    @(negedge clk);
    do_ack(1'b1, 3'b001, 3'd0, 1'b0);

    // Reset during ACK2
    irr = 8'h08; isr = 8'h00; imr = 8'h00;
    @(negedge clk);
    inta_n = 1'b0; @(negedge clk);
    inta_n = 1'b1; @(negedge clk);
    inta_n = 1'b0; @(negedge clk);
    check("mid_ack2", {31'd0, dout_en}, 32'd1);
    #2;
    rst_n = 1'b0; inta_n = 1'b1;
    #1;
    check("mid_rst_dout_en", {31'd0, dout_en}, 32'd0);
    check("mid_rst_dout", {24'd0, dout}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("mid_rst_int", {31'd0, int_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("post_rst_int", {31'd0, int_o}, 32'd1);
    do_ack(1'b0, 3'd0, 3'd0, 1'b0);

    // Randomized transactions
    for (int it = 0; it < 40; it++) begin
      irr = 8'($urandom);
      imr = 8'($urandom) & 8'($urandom);
      case ($urandom_range(0, 3))
        0: isr = 8'h00;
        1: isr = 8'd1 << $urandom_range(0, 7);
        default: isr = (8'd1 << $urandom_range(0, 7)) | (8'd1 << $urandom_range(0, 7));
      endcase
      vec_base = 5'($urandom);
      @(negedge clk);
      check("rnd_int", {31'd0, int_o}, {31'd0, cand(irr, imr, isr) >= 0});
      do_ack($urandom_range(0, 2) == 0, cmd_tab[$urandom_range(0, 4)],
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1)
        do_eoi(cmd_tab[$urandom_range(0, 4)], 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
